// File: rtl/mem_access_ctrl_mp_pkg.sv
// Shared FSM states, request/response records, cache-line geometry and byte-lane helpers
// for the multi-port memory access controller.
package mem_access_pkg;

  localparam int ADDR_W     = 32;
  localparam int LINE_BYTES = 16;
  localparam int LEN_W      = 4;
  localparam int DATA_W     = 8 * LINE_BYTES;
  localparam int OFF_W      = $clog2(LINE_BYTES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3,
    RESP  = 3'd4
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
    logic [LEN_W-1:0]  len;
    logic              r_w;
  } req_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
    logic [LEN_W-1:0]  len;
    logic              err;
  } rsp_t;

  // Overlay write bytes 0..len onto line bytes off..off+len.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] line,
                                                   input logic [DATA_W-1:0] wdat,
                                                   input logic [OFF_W-1:0]  off,
                                                   input logic [LEN_W-1:0]  len);
    logic [DATA_W-1:0] res;
    res = line;
    for (int i = 0; i < LINE_BYTES; i++) begin
      if ((i >= int'(off)) && (i <= int'(off) + int'(len))) begin
        res[8*i +: 8] = wdat[8*(i - int'(off)) +: 8];
      end else begin
        res[8*i +: 8] = line[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Shift line byte off down to lane 0; lanes beyond len read as zero.
  function automatic logic [DATA_W-1:0] byte_extract(input logic [DATA_W-1:0] line,
                                                     input logic [OFF_W-1:0]  off,
                                                     input logic [LEN_W-1:0]  len);
    logic [DATA_W-1:0] res;
    res = '0;
    for (int i = 0; i < LINE_BYTES; i++) begin
      if ((i <= int'(len)) && (int'(off) + i < LINE_BYTES)) begin
        res[8*i +: 8] = line[8*(int'(off) + i) +: 8];
      end else begin
        res[8*i +: 8] = 8'h00;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_mp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer;
// the pointer moves past the winner whenever the grant is taken.
module rr_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 advance_i,
  output logic [NUM_PORTS-1:0] grant_o
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Rotating priority search starting at the pointer.
  always_comb begin
    int   idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    grant_o = '0;
    ptr_d   = ptr_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(ptr_q) + k) % NUM_PORTS;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        ptr_d        = PTR_W'((idx + 1) % NUM_PORTS);
      end else begin
        found = found;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= ptr_d;
    end else begin
      ptr_q <= ptr_q;
    end
  end

endmodule

// File: rtl/mem_access_ctrl_mp.sv
// Multi-port memory access controller: round-robin arbitration, one transaction at a time
// against the L1 front side, read-modify-write for partial lines, per-port held responses.
module mem_access_ctrl_mp
  import mem_access_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_dat,
  input  logic [NUM_PORTS*LEN_W-1:0]  req_len,
  input  logic [NUM_PORTS-1:0]        req_r_w,
  input  logic [NUM_PORTS-1:0]        req_submit,
  output logic [NUM_PORTS-1:0]        req_acc,
  output logic [NUM_PORTS*ADDR_W-1:0] res_addr,
  output logic [NUM_PORTS*DATA_W-1:0] res_dat,
  output logic [NUM_PORTS*LEN_W-1:0]  res_len,
  output logic [NUM_PORTS-1:0]        res_err,
  output logic [NUM_PORTS-1:0]        res_rdy,
  input  logic [NUM_PORTS-1:0]        res_read,
  output logic [ADDR_W-1:0]           fs_addr,
  output logic                        fs_re,
  output logic                        fs_we,
  output logic [DATA_W-1:0]           fs_dinp,
  input  logic [DATA_W-1:0]           fs_doup,
  input  logic                        fs_suc,
  input  logic                        fs_done
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_e                state_q;
  req_t                  req_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  err_q;
  logic [DATA_W-1:0]     dat_q;
  logic                  fs_re_q;
  logic                  fs_we_q;
  logic [ADDR_W-1:0]     fs_addr_q;
  logic [DATA_W-1:0]     fs_dinp_q;
  logic [NUM_PORTS-1:0]  req_acc_q;
  logic [NUM_PORTS-1:0]  res_rdy_q;
  rsp_t                  rsp_q [NUM_PORTS];

  logic [NUM_PORTS-1:0]  elig_s;
  logic [NUM_PORTS-1:0]  grant_s;
  logic                  advance_s;
  req_t                  sel_req_s;
  logic [IDX_W-1:0]      sel_idx_s;
  logic [OFF_W-1:0]      sel_off_s;
  logic                  sel_cross_s;
  logic                  sel_full_s;
  logic [ADDR_W-1:0]     sel_line_addr_s;
  logic [OFF_W-1:0]      cur_off_s;
  logic [DATA_W-1:0]     merge_s;
  logic [DATA_W-1:0]     extract_s;

  // A port with an unconsumed response is held off: that is the only backpressure.
  assign elig_s    = req_submit & ~res_rdy_q;
  assign advance_s = (state_q == IDLE) && (|elig_s);

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (elig_s),
    .advance_i (advance_s),
    .grant_o   (grant_s)
  );

  // One-hot mux of the granted port's request fields.
  always_comb begin
    sel_req_s = '0;
    sel_idx_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      sel_req_s.addr = sel_req_s.addr | (grant_s[p] ? req_addr[p*ADDR_W +: ADDR_W] : {ADDR_W{1'b0}});
      sel_req_s.dat  = sel_req_s.dat  | (grant_s[p] ? req_dat[p*DATA_W +: DATA_W]  : {DATA_W{1'b0}});
      sel_req_s.len  = sel_req_s.len  | (grant_s[p] ? req_len[p*LEN_W +: LEN_W]    : {LEN_W{1'b0}});
      sel_req_s.r_w  = sel_req_s.r_w  | (grant_s[p] & req_r_w[p]);
      sel_idx_s      = sel_idx_s      | (grant_s[p] ? IDX_W'(p) : {IDX_W{1'b0}});
    end
  end

  assign sel_off_s       = sel_req_s.addr[OFF_W-1:0];
  assign sel_cross_s     = (int'(sel_off_s) + int'(sel_req_s.len)) > (LINE_BYTES - 1);
  assign sel_full_s      = (sel_off_s == {OFF_W{1'b0}}) && (sel_req_s.len == LEN_W'(LINE_BYTES - 1));
  assign sel_line_addr_s = {sel_req_s.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  assign cur_off_s = req_q.addr[OFF_W-1:0];
  assign merge_s   = byte_merge(fs_doup, req_q.dat, cur_off_s, req_q.len);
  assign extract_s = byte_extract(fs_doup, cur_off_s, req_q.len);

  // Transaction FSM with registered strobes, accept pulses and response registers.
  // The merged line is launched together with fs_we on leaving RD, so MERGE is also the
  // first cycle of the write phase and must already watch fs_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      fs_re_q   <= 1'b0;
      fs_we_q   <= 1'b0;
      fs_addr_q <= '0;
      fs_dinp_q <= '0;
      req_acc_q <= '0;
      res_rdy_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        rsp_q[p] <= '0;
      end
    end else begin
      req_acc_q <= '0;
      res_rdy_q <= res_rdy_q & ~res_read;
      case (state_q)
        IDLE: begin
          if (|elig_s) begin
            req_acc_q <= grant_s;
            req_q     <= sel_req_s;
            idx_q     <= sel_idx_s;
            fs_addr_q <= sel_line_addr_s;
            if (sel_cross_s) begin
              err_q   <= 1'b1;
              dat_q   <= '0;
              state_q <= RESP;
            end else if (!sel_req_s.r_w && sel_full_s) begin
              fs_we_q   <= 1'b1;
              fs_dinp_q <= sel_req_s.dat;
              state_q   <= WR;
            end else begin
              fs_re_q <= 1'b1;
              state_q <= RD;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RD: begin
          if (fs_done) begin
            fs_re_q <= 1'b0;
            if (!fs_suc) begin
              err_q   <= 1'b1;
              dat_q   <= '0;
              state_q <= RESP;
            end else if (req_q.r_w) begin
              err_q   <= 1'b0;
              dat_q   <= extract_s;
              state_q <= RESP;
            end else begin
              fs_we_q   <= 1'b1;
              fs_dinp_q <= merge_s;
              state_q   <= MERGE;
            end
          end else begin
            state_q <= RD;
          end
        end
        MERGE, WR: begin
          if (fs_done) begin
            fs_we_q <= 1'b0;
            err_q   <= !fs_suc;
            dat_q   <= '0;
            state_q <= RESP;
          end else begin
            state_q <= WR;
          end
        end
        RESP: begin
          rsp_q[idx_q]     <= '{addr: req_q.addr, dat: dat_q, len: req_q.len, err: err_q};
          res_rdy_q[idx_q] <= 1'b1;
          state_q          <= IDLE;
        end
        default: begin
          fs_re_q <= 1'b0;
          fs_we_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
    assign res_addr[p*ADDR_W +: ADDR_W] = rsp_q[p].addr;
    assign res_dat[p*DATA_W +: DATA_W]  = rsp_q[p].dat;
    assign res_len[p*LEN_W +: LEN_W]    = rsp_q[p].len;
    assign res_err[p]                   = rsp_q[p].err;
  end

  assign res_rdy = res_rdy_q;
  assign req_acc = req_acc_q;
  assign fs_addr = fs_addr_q;
  assign fs_re   = fs_re_q;
  assign fs_we   = fs_we_q;
  assign fs_dinp = fs_dinp_q;

endmodule

// File: tb/tb_mem_access_ctrl_mp.sv
// Directed bench for mem_access_ctrl_mp with a one-cycle-latency front-side cache responder.
module tb_mem_access_ctrl_mp;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int LW = 4;
  localparam logic [DW-1:0] LINE = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NP*AW-1:0] req_addr = '0;
  logic [NP*DW-1:0] req_dat = '0;
  logic [NP*LW-1:0] req_len = '0;
  logic [NP-1:0]    req_r_w = '0;
  logic [NP-1:0]    req_submit = '0;
  logic [NP-1:0]    req_acc;
  logic [NP*AW-1:0] res_addr;
  logic [NP*DW-1:0] res_dat;
  logic [NP*LW-1:0] res_len;
  logic [NP-1:0]    res_err;
  logic [NP-1:0]    res_rdy;
  logic [NP-1:0]    res_read = '0;
  logic [AW-1:0]    fs_addr;
  logic             fs_re;
  logic             fs_we;
  logic [DW-1:0]    fs_dinp;
  logic [DW-1:0]    fs_doup;
  logic             fs_suc;
  logic             fs_done = 1'b0;

  logic [DW-1:0] line_cfg = LINE;
  logic          suc_cfg = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_access_ctrl_mp #(.NUM_PORTS(NP)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_dat(req_dat), .req_len(req_len), .req_r_w(req_r_w),
    .req_submit(req_submit), .req_acc(req_acc),
    .res_addr(res_addr), .res_dat(res_dat), .res_len(res_len), .res_err(res_err),
    .res_rdy(res_rdy), .res_read(res_read),
    .fs_addr(fs_addr), .fs_re(fs_re), .fs_we(fs_we), .fs_dinp(fs_dinp),
    .fs_doup(fs_doup), .fs_suc(fs_suc), .fs_done(fs_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign fs_doup = line_cfg;
  assign fs_suc  = suc_cfg;

  // Cache model: fs_done pulses one cycle after a strobe first appears.
  int            re_cnt = 0;
  int            we_cnt = 0;
  int            both_cnt = 0;
  int            pend = 0;
  logic          prev_re = 1'b0;
  logic          prev_we = 1'b0;
  logic [AW-1:0] addr_cap = '0;
  logic [DW-1:0] wr_cap = '0;
  always @(negedge clk) begin
    fs_done = 1'b0;
    if (pend == 1) begin
      fs_done = 1'b1;
      pend = 0;
      if (fs_we) wr_cap = fs_dinp;
    end
    if ((fs_re && !prev_re) || (fs_we && !prev_we)) begin
      pend = 1;
      addr_cap = fs_addr;
      if (fs_re) re_cnt++;
      if (fs_we) we_cnt++;
    end
    if (fs_re && fs_we) both_cnt++;
    prev_re = fs_re;
    prev_we = fs_we;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input int p, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [LW-1:0] l, input logic rw,
                        output int t_acc);
    req_addr[p*AW +: AW] = a;
    req_dat[p*DW +: DW]  = d;
    req_len[p*LW +: LW]  = l;
    req_r_w[p]           = rw;
    req_submit[p]        = 1'b1;
    t_acc = -1;
    for (int i = 0; i < 20 && t_acc < 0; i++) begin
      @(negedge clk);
      if (req_acc[p]) t_acc = cyc;
    end
    req_submit[p] = 1'b0;
    chk({tag, "_accept"}, DW'(t_acc >= 0), DW'(1));
  endtask

  task automatic wait_rdy(input int p, input int t_acc, output int lat);
    lat = -1;
    for (int i = 0; i < 30 && lat < 0; i++) begin
      if (res_rdy[p]) lat = cyc - t_acc;
      else @(negedge clk);
    end
  endtask

  task automatic consume(input string tag, input int p);
    res_read[p] = 1'b1;
    @(negedge clk);
    res_read[p] = 1'b0;
    chk({tag, "_rdy_clear"}, DW'(res_rdy[p]), DW'(0));
  endtask

  int t;
  int lat;
  int re0;
  int we0;
  int ng;
  int g [4];
  int acc0;
  int acc1;
  int seen;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_fs_re", DW'(fs_re), DW'(0));
    chk("rst_fs_we", DW'(fs_we), DW'(0));
    chk("rst_acc", DW'(req_acc), DW'(0));
    chk("rst_rdy", DW'(res_rdy), DW'(0));
    chk("rst_res_dat", res_dat[DW-1:0], DW'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: port 0 read 0x104 len 3
    re0 = re_cnt; we0 = we_cnt;
    do_req("t1", 0, 32'h104, '0, 4'd3, 1'b1, t);
    wait_rdy(0, t, lat);
    chk("t1_lat", DW'(lat), DW'(3));
    chk("t1_fs_addr", DW'(addr_cap), DW'(32'h100));
    chk("t1_dat", res_dat[0 +: DW], 128'h8899AABB);
    chk("t1_err", DW'(res_err[0]), DW'(0));
    chk("t1_addr", DW'(res_addr[0 +: AW]), DW'(32'h104));
    chk("t1_len", DW'(res_len[0 +: LW]), DW'(3));
    chk("t1_re", DW'(re_cnt - re0), DW'(1));
    chk("t1_we", DW'(we_cnt - we0), DW'(0));
    consume("t1", 0);

    // 2: port 1 partial write 0x208 len 1
    re0 = re_cnt; we0 = we_cnt;
    do_req("t2", 1, 32'h208, 128'hBEEF, 4'd1, 1'b0, t);
    wait_rdy(1, t, lat);
    chk("t2_lat", DW'(lat), DW'(5));
    chk("t2_wdata", wr_cap, 128'h00112233_4455BEEF_8899AABB_CCDDEEFF);
    chk("t2_fs_addr", DW'(addr_cap), DW'(32'h200));
    chk("t2_re", DW'(re_cnt - re0), DW'(1));
    chk("t2_we", DW'(we_cnt - we0), DW'(1));
    chk("t2_dat", res_dat[DW +: DW], DW'(0));
    chk("t2_err", DW'(res_err[1]), DW'(0));
    consume("t2", 1);

    // 3: port 0 full-line write 0x300
    re0 = re_cnt; we0 = we_cnt;
    do_req("t3", 0, 32'h300, 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 4'd15, 1'b0, t);
    wait_rdy(0, t, lat);
    chk("t3_lat", DW'(lat), DW'(3));
    chk("t3_re", DW'(re_cnt - re0), DW'(0));
    chk("t3_we", DW'(we_cnt - we0), DW'(1));
    chk("t3_wdata", wr_cap, 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98);
    chk("t3_fs_addr", DW'(addr_cap), DW'(32'h300));
    consume("t3", 0);

    // Boundary: 0x10C len 3 ends exactly on the last byte
    do_req("bnd", 1, 32'h10C, '0, 4'd3, 1'b1, t);
    wait_rdy(1, t, lat);
    chk("bnd_err", DW'(res_err[1]), DW'(0));
    chk("bnd_dat", res_dat[DW +: DW], 128'h00112233);
    consume("bnd", 1);

    // 6a: crossing request 0x10E len 3
    re0 = re_cnt; we0 = we_cnt;
    do_req("t6a", 0, 32'h10E, '0, 4'd3, 1'b1, t);
    wait_rdy(0, t, lat);
    chk("t6a_err", DW'(res_err[0]), DW'(1));
    chk("t6a_dat", res_dat[0 +: DW], DW'(0));
    chk("t6a_strobes", DW'((re_cnt - re0) + (we_cnt - we0)), DW'(0));
    consume("t6a", 0);

    // 6b: cache failure on a read
    suc_cfg = 1'b0;
    do_req("t6b", 1, 32'h100, '0, 4'd0, 1'b1, t);
    wait_rdy(1, t, lat);
    chk("t6b_err", DW'(res_err[1]), DW'(1));
    chk("t6b_dat", res_dat[DW +: DW], DW'(0));
    consume("t6b", 1);
    suc_cfg = 1'b1;

    // 4: both ports submit continuously, responses consumed at once
    req_addr = {32'h100, 32'h100};
    req_len  = '0;
    req_r_w  = 2'b11;
    req_submit = 2'b11;
    ng = 0;
    g = '{-1, -1, -1, -1};
    for (int i = 0; i < 80 && ng < 4; i++) begin
      @(negedge clk);
      res_read = res_rdy;
      if (req_acc[0]) begin g[ng] = 0; ng++; end
      else if (req_acc[1]) begin g[ng] = 1; ng++; end
    end
    req_submit = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      res_read = res_rdy;
    end
    res_read = '0;
    chk("t4_count", DW'(ng), DW'(4));
    chk("t4_g0", DW'(g[0]), DW'(0));
    chk("t4_g1", DW'(g[1]), DW'(1));
    chk("t4_g2", DW'(g[2]), DW'(0));
    chk("t4_g3", DW'(g[3]), DW'(1));
    chk("t4_drained", DW'(res_rdy), DW'(0));

    // 5: unread port-0 response blocks port 0 only
    do_req("t5", 0, 32'h104, '0, 4'd3, 1'b1, t);
    wait_rdy(0, t, lat);
    req_addr[AW +: AW] = 32'h204;
    req_len[LW +: LW]  = 4'd0;
    req_r_w[1]         = 1'b1;
    req_submit = 2'b11;
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      res_read[1] = res_rdy[1];
      if (req_acc[0]) acc0++;
      if (req_acc[1]) acc1++;
    end
    req_submit[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      res_read[1] = res_rdy[1];
      if (req_acc[0]) acc0++;
    end
    res_read[1] = 1'b0;
    chk("t5_p0_blocked", DW'(acc0), DW'(0));
    chk("t5_p1_many", DW'(acc1 >= 3), DW'(1));
    chk("t5_p0_held", DW'(res_rdy[0]), DW'(1));
    res_read[0] = 1'b1;
    @(negedge clk);
    res_read[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (req_acc[0]) seen = 1;
    end
    req_submit[0] = 1'b0;
    chk("t5_p0_after_read", DW'(seen), DW'(1));
    t = cyc;
    wait_rdy(0, t, lat);
    consume("t5", 0);

    // 6c: reset while writing
    do_req("t6c", 0, 32'h300, 128'h1, 4'd15, 1'b0, t);
    chk("t6c_we_on", DW'(fs_we), DW'(1));
    #1 rst = 1'b0;
    #1;
    chk("t6c_we_drop", DW'(fs_we), DW'(0));
    chk("t6c_re_drop", DW'(fs_re), DW'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6c_no_rsp", DW'(res_rdy), DW'(0));
    chk("t6c_idle_we", DW'(fs_we), DW'(0));

    chk("never_both_strobes", DW'(both_cnt), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
